// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Holds the state encoding and the round-robin priority update rule.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int NUM_REQ    = 2;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } arb_state_t;

    // Priority value 1 means requester 1 wins a tie; the loser of the last grant is favoured next.
    function automatic logic next_prio(input logic [NUM_REQ-1:0] grant);
        return grant[0];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; purely combinational one-hot grant.
// A lone request always wins; prio_sel only breaks a tie.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       prio_sel,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = prio_sel ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single synchronous RAM port between two requesters and clears the RAM
// to INIT_VALUE after reset or on init_req.
//
// state  | meaning
// S_INIT | sweeping every address with INIT_VALUE, requesters stalled
// S_RUN  | round-robin service of read/write requests
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            init_req,
    output logic                            init_busy,
    input  logic [NUM_REQ-1:0]              rq_valid,
    output logic [NUM_REQ-1:0]              rq_ready,
    input  logic [NUM_REQ-1:0]              rq_write,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  rq_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  rq_wdata,
    output logic [NUM_REQ-1:0]              rs_valid,
    output logic [DATA_W-1:0]               rs_rdata,
    output logic                            a_en,
    output logic                            a_write_en,
    output logic [ADDR_W-1:0]               a_addr,
    output logic [DATA_W-1:0]               a_wdata,
    input  logic [DATA_W-1:0]               a_rdata
);

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    arb_state_t         state, state_nxt;
    logic [ADDR_W-1:0]  clr_cnt, clr_cnt_nxt;
    logic               prio, prio_nxt;
    logic [NUM_REQ-1:0] rs_valid_q, rs_valid_nxt;
    logic [NUM_REQ-1:0] grant;
    logic               gnt_idx;

    rr_arbiter2 u_rr (
        .valid    (rq_valid),
        .prio_sel (prio),
        .grant    (grant)
    );

    assign gnt_idx = grant[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_INIT;
            clr_cnt    <= '0;
            prio       <= 1'b0;
            rs_valid_q <= '0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            prio       <= prio_nxt;
            rs_valid_q <= rs_valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        prio_nxt     = prio;
        rs_valid_nxt = '0;
        case (state)
            S_INIT: begin
                if (init_req) begin
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                    if (clr_cnt == CNT_LAST) begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // The grant of this cycle completes even when init_req arrives alongside it.
                if (|grant) begin
                    prio_nxt     = next_prio(grant);
                    rs_valid_nxt = grant & ~rq_write;
                end
                if (init_req) begin
                    state_nxt   = S_INIT;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = S_INIT;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        init_busy  = (state == S_INIT);
        rq_ready   = '0;
        a_en       = 1'b0;
        a_write_en = 1'b0;
        a_addr     = clr_cnt;
        a_wdata    = INIT_VALUE;
        // The RAM port stays quiet for the whole time reset is held.
        if (!reset) begin
            if (state == S_INIT) begin
                a_en       = 1'b1;
                a_write_en = 1'b1;
            end else if (|grant) begin
                rq_ready   = grant;
                a_en       = 1'b1;
                a_write_en = rq_write[gnt_idx];
                a_addr     = rq_addr[gnt_idx];
                a_wdata    = rq_wdata[gnt_idx];
            end
        end
    end

    assign rs_valid = rs_valid_q;
    assign rs_rdata = a_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural one-cycle-latency RAM on port A.
module tb_ram_port_arbiter;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             init_req = 1'b0;
    logic             init_busy;
    logic [1:0]       rq_valid = 2'b00;
    logic [1:0]       rq_ready;
    logic [1:0]       rq_write = 2'b00;
    logic [1:0][9:0]  rq_addr = '0;
    logic [1:0][7:0]  rq_wdata = '0;
    logic [1:0]       rs_valid;
    logic [7:0]       rs_rdata;
    logic             a_en;
    logic             a_write_en;
    logic [9:0]       a_addr;
    logic [7:0]       a_wdata;
    logic [7:0]       a_rdata;

    logic [7:0]       mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    ram_port_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .init_req   (init_req),
        .init_busy  (init_busy),
        .rq_valid   (rq_valid),
        .rq_ready   (rq_ready),
        .rq_write   (rq_write),
        .rq_addr    (rq_addr),
        .rq_wdata   (rq_wdata),
        .rs_valid   (rs_valid),
        .rs_rdata   (rs_rdata),
        .a_en       (a_en),
        .a_write_en (a_write_en),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_rdata    (a_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (a_en) begin
            if (a_write_en) mem[a_addr] <= a_wdata;
            else            a_rdata     <= mem[a_addr];
        end
    end

    task automatic test_reset;
        reset    = 1'b1;
        rq_valid = 2'b11;
        #1;
        n_cmp++;
        if ({init_busy, a_en, a_write_en, rq_ready, rs_valid} !== 7'b1_0_0_00_00) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {init_busy, a_en, a_write_en, rq_ready, rs_valid}, 7'b1_0_0_00_00);
        end
        rq_valid = 2'b00;
    endtask

    task automatic test_clear;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 1024; c++) begin
            #1;
            n_cmp++;
            if ({init_busy, a_en, a_write_en, a_addr, a_wdata, rq_ready} !== {3'b111, 10'(c), 8'h00, 2'b00}) begin
                n_err++;
                $display("FAIL clear_sweep[%0d]: got busy=%b en=%b we=%b addr=%0d wdata=%h rdy=%b", c,
                         init_busy, a_en, a_write_en, a_addr, a_wdata, rq_ready);
            end
            @(negedge clock);
        end
        #1;
        n_cmp++;
        if ({init_busy, a_en, a_write_en} !== 3'b000) begin
            n_err++;
            $display("FAIL clear_done: got busy/en/we=%b expected 000", {init_busy, a_en, a_write_en});
        end
    endtask

    task automatic test_write_read;
        @(negedge clock);
        rq_valid = 2'b01; rq_write = 2'b01; rq_addr[0] = 10'd5; rq_wdata[0] = 8'hA5;
        #1;
        n_cmp++;
        if ({rq_ready, a_en, a_write_en, a_addr, a_wdata} !== {2'b01, 1'b1, 1'b1, 10'd5, 8'hA5}) begin
            n_err++;
            $display("FAIL wr0_grant: got rdy=%b en=%b we=%b addr=%0d wdata=%h", rq_ready, a_en, a_write_en, a_addr, a_wdata);
        end
        @(negedge clock);
        rq_write = 2'b00;
        #1;
        n_cmp++;
        if ({rq_ready, a_en, a_write_en, a_addr, rs_valid} !== {2'b01, 1'b1, 1'b0, 10'd5, 2'b00}) begin
            n_err++;
            $display("FAIL rd0_grant: got rdy=%b en=%b we=%b addr=%0d rsv=%b", rq_ready, a_en, a_write_en, a_addr, rs_valid);
        end
        @(negedge clock);
        rq_valid = 2'b00;
        #1;
        n_cmp++;
        if ({rs_valid, rs_rdata, a_en} !== {2'b01, 8'hA5, 1'b0}) begin
            n_err++;
            $display("FAIL rd0_resp: got rsv=%b rdata=%h en=%b expected 01 a5 0", rs_valid, rs_rdata, a_en);
        end
        @(negedge clock);
        #1;
        n_cmp++;
        if (rs_valid !== 2'b00) begin
            n_err++;
            $display("FAIL rd0_resp_once: got rsv=%b expected 00", rs_valid);
        end
    endtask

    task automatic test_init_during_read;
        @(negedge clock);
        rq_valid = 2'b10; rq_write = 2'b10; rq_addr[1] = 10'd7; rq_wdata[1] = 8'h3C;
        #1;
        n_cmp++;
        if (rq_ready !== 2'b10) begin
            n_err++;
            $display("FAIL wr1_grant: got rdy=%b expected 10", rq_ready);
        end
        @(negedge clock);
        rq_write = 2'b00; init_req = 1'b1;
        #1;
        n_cmp++;
        if ({rq_ready, a_write_en, a_addr} !== {2'b10, 1'b0, 10'd7}) begin
            n_err++;
            $display("FAIL rd1_with_init: got rdy=%b we=%b addr=%0d", rq_ready, a_write_en, a_addr);
        end
        @(negedge clock);
        init_req = 1'b0; rq_valid = 2'b00;
        #1;
        n_cmp++;
        if ({rs_valid, rs_rdata, init_busy, a_en, a_write_en, a_addr} !== {2'b10, 8'h3C, 3'b111, 10'd0}) begin
            n_err++;
            $display("FAIL init_after_rd1: got rsv=%b rdata=%h busy=%b en=%b we=%b addr=%0d",
                     rs_valid, rs_rdata, init_busy, a_en, a_write_en, a_addr);
        end
        for (int i = 0; i < 1100 && init_busy; i++) @(negedge clock);
        n_cmp++;
        if (init_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reinit_timeout: init_busy=%b expected 0", init_busy);
        end
        @(negedge clock);
        rq_valid = 2'b10; rq_write = 2'b00; rq_addr[1] = 10'd7;
        @(negedge clock);
        rq_valid = 2'b00;
        #1;
        n_cmp++;
        if ({rs_valid, rs_rdata} !== {2'b10, 8'h00}) begin
            n_err++;
            $display("FAIL rd7_after_clear: got rsv=%b rdata=%h expected 10 00", rs_valid, rs_rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] addrs [3];
        logic [7:0] datas [3];
        logic [1:0] exp_g [4];
        addrs = '{10'd7, 10'd8, 10'd9};
        datas = '{8'h77, 8'h88, 8'h99};
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            rq_valid = 2'b10; rq_write = 2'b10; rq_addr[1] = addrs[k]; rq_wdata[1] = datas[k];
            #1;
            n_cmp++;
            if ({rq_ready, a_write_en, a_addr, a_wdata, rs_valid} !== {2'b10, 1'b1, addrs[k], datas[k], 2'b00}) begin
                n_err++;
                $display("FAIL b2b_req1[%0d]: got rdy=%b we=%b addr=%0d wdata=%h rsv=%b", k,
                         rq_ready, a_write_en, a_addr, a_wdata, rs_valid);
            end
        end
        @(negedge clock);
        rq_valid = 2'b11; rq_write = 2'b00; rq_addr[0] = 10'd9; rq_addr[1] = 10'd8;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if ({rq_ready, a_addr} !== {exp_g[k], (exp_g[k] == 2'b01) ? 10'd9 : 10'd8}) begin
                n_err++;
                $display("FAIL both_grant[%0d]: got rdy=%b addr=%0d expected %b", k, rq_ready, a_addr, exp_g[k]);
            end
            n_cmp++;
            if (k == 0) begin
                if (rs_valid !== 2'b00) begin
                    n_err++;
                    $display("FAIL both_rsv[0]: got %b expected 00", rs_valid);
                end
            end else if ({rs_valid, rs_rdata} !== {exp_g[k-1], (exp_g[k-1] == 2'b01) ? 8'h99 : 8'h88}) begin
                n_err++;
                $display("FAIL both_rsv[%0d]: got rsv=%b rdata=%h", k, rs_valid, rs_rdata);
            end
            @(negedge clock);
        end
        rq_valid = 2'b00;
        #1;
        n_cmp++;
        if ({rs_valid, rs_rdata, a_en} !== {2'b10, 8'h88, 1'b0}) begin
            n_err++;
            $display("FAIL both_last_rsv: got rsv=%b rdata=%h en=%b expected 10 88 0", rs_valid, rs_rdata, a_en);
        end
    endtask

    task automatic test_reset_mid_ops;
        @(negedge clock);
        rq_valid = 2'b01; rq_write = 2'b00; rq_addr[0] = 10'd9;
        #1;
        n_cmp++;
        if (rq_ready !== 2'b01) begin
            n_err++;
            $display("FAIL abort_rd_grant: got %b expected 01", rq_ready);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({rq_ready, a_en, init_busy} !== 4'b00_0_1) begin
            n_err++;
            $display("FAIL abort_rd_reset: got rdy=%b en=%b busy=%b", rq_ready, a_en, init_busy);
        end
        rq_valid = 2'b00;
        @(negedge clock);
        #1;
        n_cmp++;
        if (rs_valid !== 2'b00) begin
            n_err++;
            $display("FAIL abort_rd_rsv: got %b expected 00", rs_valid);
        end
        reset = 1'b0;
        repeat (300) @(negedge clock);
        #1;
        n_cmp++;
        if ({init_busy, a_addr} !== {1'b1, 10'd300}) begin
            n_err++;
            $display("FAIL clear_at_300: got busy=%b addr=%0d", init_busy, a_addr);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({a_en, init_busy} !== 2'b01) begin
            n_err++;
            $display("FAIL clear_reset_held: got en=%b busy=%b expected 0 1", a_en, init_busy);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({a_en, a_write_en, a_addr} !== {2'b11, 10'd0}) begin
            n_err++;
            $display("FAIL clear_restart: got en=%b we=%b addr=%0d expected addr 0", a_en, a_write_en, a_addr);
        end
        repeat (10) @(negedge clock);
        init_req = 1'b1;
        #1;
        n_cmp++;
        if (a_addr !== 10'd10) begin
            n_err++;
            $display("FAIL clear_at_10: got addr=%0d expected 10", a_addr);
        end
        @(negedge clock);
        init_req = 1'b0;
        #1;
        n_cmp++;
        if ({init_busy, a_addr} !== {1'b1, 10'd0}) begin
            n_err++;
            $display("FAIL init_req_restart: got busy=%b addr=%0d expected 1 0", init_busy, a_addr);
        end
        for (int i = 0; i < 1100 && init_busy; i++) @(negedge clock);
        n_cmp++;
        if (init_busy !== 1'b0) begin
            n_err++;
            $display("FAIL final_clear_timeout: init_busy=%b expected 0", init_busy);
        end
    endtask

    initial begin
        test_reset;
        test_clear;
        test_write_read;
        test_init_during_read;
        test_back_to_back;
        test_reset_mid_ops;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
